// File: rtl/abr_prim_count_pkg.sv
// Shared types and helpers for the redundant security counter.
// Contents:
//   abr_count_cmd_e    one-hot-free command produced by the priority encoder
//   sat_add / sat_sub  saturating arithmetic on up to MaxW-bit operands,
//                      with the effective width passed in at run time
package abr_prim_count_pkg;

   localparam int unsigned MaxW = 32;

   typedef enum logic [2:0] {
      CmdHold = 3'd0,
      CmdClr  = 3'd1,
      CmdSet  = 3'd2,
      CmdIncr = 3'd3,
      CmdDecr = 3'd4
   } abr_count_cmd_e;

   // a + b, clamped to the all-ones value of a w-bit counter
   function automatic logic [MaxW-1:0] sat_add(input logic [MaxW-1:0] a,
                                               input logic [MaxW-1:0] b,
                                               input int unsigned     w);
      logic [MaxW:0] sum;
      logic [MaxW:0] maxv;
      sum  = {1'b0, a} + {1'b0, b};
      maxv = ((MaxW+1)'(1) << w) - (MaxW+1)'(1);
      return (sum > maxv) ? maxv[MaxW-1:0] : sum[MaxW-1:0];
   endfunction

   // a - b, clamped to 0
   function automatic logic [MaxW-1:0] sat_sub(input logic [MaxW-1:0] a,
                                               input logic [MaxW-1:0] b);
      return (b > a) ? '0 : (a - b);
   endfunction

endpackage

// File: rtl/abr_prim_flop.sv
// Plain register with synchronous active-high reset; one instance per
// redundant copy keeps the copies as distinct cells.
// Ports:
//   clk_i  clock
//   rst_i  synchronous reset, loads ResetValue
//   d_i    next value
//   q_o    registered value
module abr_prim_flop #(
   parameter int unsigned      Width      = 8,
   parameter logic [Width-1:0] ResetValue = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] q_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) q_q <= ResetValue;
      else       q_q <= d_i;
   end

   assign q_o = q_q;

endmodule

// File: rtl/abr_prim_sec_anchor_buf.sv
// Anchor buffer: a preserved boundary so synthesis cannot see through to
// merge the redundant copies or optimise away the consistency checker.
// Ports:
//   in_i   value to anchor
//   out_o  anchored value
module abr_prim_sec_anchor_buf #(
   parameter int unsigned Width = 8
) (
   input  logic [Width-1:0] in_i,
   output logic [Width-1:0] out_o
);

   assign out_o = in_i;

endmodule

// File: rtl/abr_prim_sec_count.sv
// Hardened saturating up/down counter. Keeps a primary count and an
// inverted-sense secondary count in separate registers, each updated from
// its own anchored value; any disagreement raises a sticky fault.
// Ports:
//   clk_i               clock
//   rst_i               synchronous active-high reset
//   clr_i               load ResetValue
//   set_i               load set_cnt_i
//   set_cnt_i           value for set
//   incr_en_i           saturating add of step_i
//   decr_en_i           saturating subtract of step_i
//   step_i              step magnitude
//   cnt_o               anchored primary count
//   cnt_after_commit_o  combinational next primary value
//   err_o               redundancy fault (live mismatch OR latched)
module abr_prim_sec_count
   import abr_prim_count_pkg::*;
#(
   parameter int unsigned      Width      = 8,
   parameter logic [Width-1:0] ResetValue = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             set_i,
   input  logic [Width-1:0] set_cnt_i,
   input  logic             incr_en_i,
   input  logic             decr_en_i,
   input  logic [Width-1:0] step_i,
   output logic [Width-1:0] cnt_o,
   output logic [Width-1:0] cnt_after_commit_o,
   output logic             err_o
);

   abr_count_cmd_e   cmd;
   logic [Width-1:0] cnt_d, cnt_q, cnt_a;
   logic [Width-1:0] cnt_n_d, cnt_n_q, cnt_n_a;
   logic             mismatch;
   logic             err_d, err_q;

   // Priority encoder; a zero step is folded into hold
   always_comb begin
      cmd = CmdHold;
      if (clr_i)                                       cmd = CmdClr;
      else if (set_i)                                  cmd = CmdSet;
      else if ((incr_en_i ^ decr_en_i) && (step_i != '0))
         cmd = incr_en_i ? CmdIncr : CmdDecr;
   end

   // Next values; each copy is derived only from its own anchored register
   always_comb begin
      cnt_d   = cnt_a;
      cnt_n_d = cnt_n_a;
      unique case (cmd)
         CmdClr: begin
            cnt_d   = ResetValue;
            cnt_n_d = ~ResetValue;
         end
         CmdSet: begin
            cnt_d   = set_cnt_i;
            cnt_n_d = ~set_cnt_i;
         end
         CmdIncr: begin
            cnt_d   = Width'(sat_add(MaxW'(cnt_a), MaxW'(step_i), Width));
            cnt_n_d = Width'(sat_sub(MaxW'(cnt_n_a), MaxW'(step_i)));
         end
         CmdDecr: begin
            cnt_d   = Width'(sat_sub(MaxW'(cnt_a), MaxW'(step_i)));
            cnt_n_d = Width'(sat_add(MaxW'(cnt_n_a), MaxW'(step_i), Width));
         end
         default: begin
            cnt_d   = cnt_a;
            cnt_n_d = cnt_n_a;
         end
      endcase
   end

   abr_prim_flop #(.Width(Width), .ResetValue(ResetValue)) u_cnt_flop (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (cnt_d),
      .q_o   (cnt_q)
   );

   abr_prim_flop #(.Width(Width), .ResetValue(~ResetValue)) u_cnt_n_flop (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (cnt_n_d),
      .q_o   (cnt_n_q)
   );

   abr_prim_sec_anchor_buf #(.Width(Width)) u_cnt_buf (
      .in_i  (cnt_q),
      .out_o (cnt_a)
   );

   abr_prim_sec_anchor_buf #(.Width(Width)) u_cnt_n_buf (
      .in_i  (cnt_n_q),
      .out_o (cnt_n_a)
   );

   // Copies must always be exact complements
   assign mismatch = (cnt_a ^ cnt_n_a) != {Width{1'b1}};
   assign err_d    = err_q | mismatch;

   always_ff @(posedge clk_i) begin
      if (rst_i) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign cnt_o              = cnt_a;
   assign cnt_after_commit_o = cnt_d;
   assign err_o              = mismatch | err_q;

   // Saturating arithmetic: an increment never lowers, a decrement never raises
   incr_no_wrap_a: assert property (@(posedge clk_i) disable iff (rst_i)
      (cmd == CmdIncr) |=> (cnt_o >= $past(cnt_o)));
   decr_no_wrap_a: assert property (@(posedge clk_i) disable iff (rst_i)
      (cmd == CmdDecr) |=> (cnt_o <= $past(cnt_o)));

endmodule

// File: tb/tb_abr_prim_sec_count.sv
// Bench for abr_prim_sec_count (Width=8, ResetValue=8'h05): directed vector
// table, fault-injection sequence and randomized traffic against a model.
module tb_abr_prim_sec_count;

   localparam int unsigned W = 8;
   localparam logic [W-1:0] RV = 8'h05;

   logic         clk = 1'b0;
   logic         rst_i = 1'b1;
   logic         clr_i = 1'b0;
   logic         set_i = 1'b0;
   logic [W-1:0] set_cnt_i = '0;
   logic         incr_en_i = 1'b0;
   logic         decr_en_i = 1'b0;
   logic [W-1:0] step_i = '0;
   logic [W-1:0] cnt_o;
   logic [W-1:0] cnt_after_commit_o;
   logic         err_o;

   int checks = 0;
   int errors = 0;
   int model_cnt = 0;
   bit started = 1'b0;
   bit fault_window = 1'b0;
   logic [W-1:0] inj_val = '0;

   always #5 clk = ~clk;

   abr_prim_sec_count #(.Width(W), .ResetValue(RV)) dut (
      .clk_i              (clk),
      .rst_i              (rst_i),
      .clr_i              (clr_i),
      .set_i              (set_i),
      .set_cnt_i          (set_cnt_i),
      .incr_en_i          (incr_en_i),
      .decr_en_i          (decr_en_i),
      .step_i             (step_i),
      .cnt_o              (cnt_o),
      .cnt_after_commit_o (cnt_after_commit_o),
      .err_o              (err_o)
   );

   // Outside a deliberate fault window the fault flag must stay low
   no_spurious_err_a: assert property (@(posedge clk)
      disable iff (!started || fault_window) !err_o);

   typedef struct {
      logic         rst;
      logic         clr;
      logic         set;
      logic [W-1:0] set_cnt;
      logic         incr;
      logic         decr;
      logic [W-1:0] step;
      logic [W-1:0] exp_cnt;
   } vec_t;

   function automatic vec_t mk(logic r, logic c, logic s, logic [W-1:0] sc,
                               logic i, logic d, logic [W-1:0] st,
                               logic [W-1:0] e);
      vec_t v;
      v.rst = r; v.clr = c; v.set = s; v.set_cnt = sc;
      v.incr = i; v.decr = d; v.step = st; v.exp_cnt = e;
      return v;
   endfunction

   // Reference: the counter as a clamped integer in 0..255
   function automatic int model_next(int cur, vec_t v);
      if (v.rst || v.clr) return int'(RV);
      if (v.set) return int'(v.set_cnt);
      if (v.incr && !v.decr) return (cur + int'(v.step) > 255) ? 255 : cur + int'(v.step);
      if (v.decr && !v.incr) return (int'(v.step) > cur) ? 0 : cur - int'(v.step);
      return cur;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      rst_i = v.rst; clr_i = v.clr; set_i = v.set; set_cnt_i = v.set_cnt;
      incr_en_i = v.incr; decr_en_i = v.decr; step_i = v.step;
   endtask

   // One cycle: drive at negedge, check pending value, then registered result
   task automatic apply(input vec_t v, input string name, input logic exp_err);
      int nxt;
      @(negedge clk);
      drive(v);
      nxt = model_next(model_cnt, v);
      #1;
      if (!v.rst) chk({name, "_commit"}, 32'(cnt_after_commit_o), 32'(nxt));
      @(posedge clk);
      #1;
      chk({name, "_cnt"}, 32'(cnt_o), 32'(v.exp_cnt));
      chk({name, "_err"}, 32'(err_o), 32'(exp_err));
      model_cnt = nxt;
   endtask

   vec_t vecs[16];
   vec_t rv;

   initial begin
      // rst clr set  setcnt  inc  dec  step   expected cnt_o
      vecs[0]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h05); // reset
      vecs[1]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h05); // idle
      vecs[2]  = mk(1'b0, 1'b0, 1'b1, 8'hFA, 1'b0, 1'b0, 8'h00, 8'hFA);
      vecs[3]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 8'hFD);
      vecs[4]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 8'hFF); // carry
      vecs[5]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 8'hFF); // held at max
      vecs[6]  = mk(1'b0, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 8'h04);
      vecs[7]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 8'h01);
      vecs[8]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 8'h00); // floor
      vecs[9]  = mk(1'b0, 1'b1, 1'b1, 8'h40, 1'b1, 1'b0, 8'h01, 8'h05); // clr wins
      vecs[10] = mk(1'b0, 1'b0, 1'b1, 8'h40, 1'b1, 1'b0, 8'h01, 8'h40); // set wins
      vecs[11] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h07, 8'h40); // both: hold
      vecs[12] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h40); // zero step
      vecs[13] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 8'h00); // step > cnt
      vecs[14] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h00);
      vecs[15] = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h05);

      for (int i = 0; i < 16; i++) begin
         apply(vecs[i], $sformatf("vec%0d", i), 1'b0);
         if (i == 0) started = 1'b1;
      end

      // Fault injection: corrupt the secondary copy for one cycle while counting
      apply(mk(1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h10), "pre_fault", 1'b0);
      @(negedge clk);
      drive(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 8'h00));
      inj_val = ~8'h10 ^ 8'h01;
      fault_window = 1'b1;
      force dut.cnt_n_q = inj_val;
      #1;
      chk("fault_err_same_cycle", 32'(err_o), 32'd1);
      chk("fault_commit", 32'(cnt_after_commit_o), 32'h11);
      @(posedge clk);
      #1;
      release dut.cnt_n_q;
      model_cnt = 'h11;
      chk("fault_cnt", 32'(cnt_o), 32'h11);
      chk("fault_err_next", 32'(err_o), 32'd1);
      for (int i = 0; i < 3; i++)
         apply(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 8'(8'h12 + i)),
               $sformatf("post_fault%0d", i), 1'b1);

      // Reset mid-increment drops the increment and clears the latched fault
      apply(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 8'h05), "rst_clear", 1'b0);
      fault_window = 1'b0;
      apply(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h05), "post_rst_idle", 1'b0);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         rv.rst     = ($urandom_range(0, 63) == 0);
         rv.clr     = ($urandom_range(0, 31) == 0);
         rv.set     = ($urandom_range(0, 15) == 0);
         rv.set_cnt = 8'($urandom);
         rv.incr    = 1'($urandom);
         rv.decr    = 1'($urandom);
         rv.step    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
         rv.exp_cnt = 8'(model_next(model_cnt, rv));
         apply(rv, $sformatf("rand%0d", i), 1'b0);
      end

      drive(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
